// File: rtl/frame_buffer_ctrl.sv
// Write-side controller for a double-buffered camera frame store.
// Camera pixels go into the write bank. Each completed frame is handed to the
// reader bank, but only when the reader has released that bank.
module frame_buffer_ctrl #(
    parameter int ADDR_WIDTH   = 18,
    parameter int FRAME_PIXELS = 76800
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cam_vsync,
    input  logic                  cam_pix_valid,
    input  logic [15:0]           cam_pix_data,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [15:0]           ram_dina,
    output logic                  rd_frame_valid,
    output logic                  rd_bank,
    input  logic                  rd_done,
    output logic [15:0]           frame_count,
    output logic [15:0]           drop_count,
    output logic [15:0]           short_count,
    output logic                  busy
);

    localparam int IW = ADDR_WIDTH - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        PUBLISH
    } state_t;

    state_t                  state_q;
    logic                    wr_bank_q;
    logic                    rd_bank_q;
    logic                    rd_valid_q;
    logic                    wea_q;
    logic [ADDR_WIDTH-1:0]   addra_q;
    logic [15:0]             dina_q;
    logic [15:0]             frame_q;
    logic [15:0]             drop_q;
    logic [15:0]             short_q;
    logic                    vsync_q;
    logic [IW-1:0]           pix_idx_q;

    logic                    vs_rise;
    logic                    reader_free;
    logic [IW-1:0]           cur_idx;
    logic [IW-1:0]           pix_idx_d;

    // A fresh vsync edge restarts the frame, so any pixel that arrives with it
    // takes index 0. The reader bank may be reused if it was never claimed or
    // is being released in this same cycle.
    always_comb begin
        vs_rise     = cam_vsync & ~vsync_q;
        cur_idx     = vs_rise ? '0 : pix_idx_q;
        pix_idx_d   = cur_idx + 1'b1;
        reader_free = ~rd_valid_q | rd_done;
    end

    // Main capture FSM. It also holds the registered RAM write port, the bank
    // handshake and the statistics counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b1;
            rd_valid_q <= 1'b0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            frame_q    <= '0;
            drop_q     <= '0;
            short_q    <= '0;
            vsync_q    <= 1'b0;
            pix_idx_q  <= '0;
        end else begin
            vsync_q <= cam_vsync;
            wea_q   <= 1'b0;
            if (rd_done) begin
                rd_valid_q <= 1'b0;
            end
            if (!enable) begin
                state_q   <= IDLE;
                pix_idx_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= WAIT_VS;
                    end
                    WAIT_VS: begin
                        if (vs_rise) begin
                            state_q   <= CAPTURE;
                            pix_idx_q <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (vs_rise) begin
                            short_q   <= short_q + 16'd1;
                            pix_idx_q <= '0;
                        end
                        if (cam_pix_valid) begin
                            wea_q   <= 1'b1;
                            addra_q <= {wr_bank_q, cur_idx};
                            dina_q  <= cam_pix_data;
                            if (cur_idx == LAST_IDX) begin
                                state_q   <= PUBLISH;
                                pix_idx_q <= '0;
                            end else begin
                                pix_idx_q <= pix_idx_d;
                            end
                        end
                    end
                    PUBLISH: begin
                        state_q <= WAIT_VS;
                        if (reader_free) begin
                            rd_bank_q  <= wr_bank_q;
                            wr_bank_q  <= ~wr_bank_q;
                            rd_valid_q <= 1'b1;
                            frame_q    <= frame_q + 16'd1;
                        end else begin
                            drop_q <= drop_q + 16'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ram_wea        = wea_q;
    assign ram_addra      = addra_q;
    assign ram_dina       = dina_q;
    assign rd_frame_valid = rd_valid_q;
    assign rd_bank        = rd_bank_q;
    assign frame_count    = frame_q;
    assign drop_count     = drop_q;
    assign short_count    = short_q;
    assign busy           = (state_q == CAPTURE);

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed self-checking bench for frame_buffer_ctrl with 16-pixel frames.
module tb_frame_buffer_ctrl;

    localparam int AW = 18;
    localparam int FP = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          cam_vsync;
    logic          cam_pix_valid;
    logic [15:0]   cam_pix_data;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [15:0]   ram_dina;
    logic          rd_frame_valid;
    logic          rd_bank;
    logic          rd_done;
    logic [15:0]   frame_count;
    logic [15:0]   drop_count;
    logic [15:0]   short_count;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int badWrites = 0;

    frame_buffer_ctrl #(.ADDR_WIDTH(AW), .FRAME_PIXELS(FP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .cam_vsync      (cam_vsync),
        .cam_pix_valid  (cam_pix_valid),
        .cam_pix_data   (cam_pix_data),
        .ram_wea        (ram_wea),
        .ram_addra      (ram_addra),
        .ram_dina       (ram_dina),
        .rd_frame_valid (rd_frame_valid),
        .rd_bank        (rd_bank),
        .rd_done        (rd_done),
        .frame_count    (frame_count),
        .drop_count     (drop_count),
        .short_count    (short_count),
        .busy           (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watch for any write that lands in the bank the reader currently owns.
    always @(negedge clk) begin
        if (rst_n && ram_wea && rd_frame_valid && (ram_addra[AW-1] == rd_bank)) begin
            badWrites++;
        end
    end

    // Drive one cycle of inputs, then settle just after the clock edge.
    task automatic applyStimulus(input logic vs, input logic valid,
                                 input logic [15:0] data, input logic done);
        cam_vsync     = vs;
        cam_pix_valid = valid;
        cam_pix_data  = data;
        rd_done       = done;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send one pixel and check that it is written one cycle later.
    task automatic sendPixel(input logic vs, input logic [15:0] data,
                             input logic [AW-1:0] expAddr);
        applyStimulus(vs, 1'b1, data, 1'b0);
        checkOutput("wea", 32'(ram_wea), 32'd1);
        checkOutput("addr", 32'(ram_addra), 32'(expAddr));
        checkOutput("din", 32'(ram_dina), 32'(data));
    endtask

    // Send a vsync pulse and a full frame, then run the publish cycle.
    task automatic sendFrame(input logic bank, input logic [15:0] base,
                             input logic doneAtPublish);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
        checkOutput("busy_cap", 32'(busy), 32'd1);
        for (int k = 0; k < FP; k++) begin
            sendPixel(1'b0, base + 16'(k), {bank, 17'(k)});
        end
        applyStimulus(1'b0, 1'b0, 16'h0, doneAtPublish);
    endtask

    // Apply a synchronous reset, then move from IDLE into WAIT_VS.
    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b1;
        cam_vsync = 1'b0;
        cam_pix_valid = 1'b0;
        cam_pix_data = 16'h0;
        rd_done = 1'b0;

        // Reset values.
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("rst_wea", 32'(ram_wea), 32'd0);
        checkOutput("rst_addr", 32'(ram_addra), 32'd0);
        checkOutput("rst_din", 32'(ram_dina), 32'd0);
        checkOutput("rst_valid", 32'(rd_frame_valid), 32'd0);
        checkOutput("rst_rdbank", 32'(rd_bank), 32'd1);
        checkOutput("rst_frames", 32'(frame_count), 32'd0);
        checkOutput("rst_drops", 32'(drop_count), 32'd0);
        checkOutput("rst_shorts", 32'(short_count), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

        // First frame goes to bank 0 and is published to the reader.
        sendFrame(1'b0, 16'h0000, 1'b0);
        checkOutput("f1_valid", 32'(rd_frame_valid), 32'd1);
        checkOutput("f1_rdbank", 32'(rd_bank), 32'd0);
        checkOutput("f1_frames", 32'(frame_count), 32'd1);
        checkOutput("f1_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b1, 16'hABCD, 1'b0);
        checkOutput("waitvs_ignore", 32'(ram_wea), 32'd0);

        // The reader keeps its bank, so the next two frames are dropped in bank 1.
        sendFrame(1'b1, 16'h0010, 1'b0);
        sendFrame(1'b1, 16'h0020, 1'b0);
        checkOutput("drop_count", 32'(drop_count), 32'd2);
        checkOutput("drop_rdbank", 32'(rd_bank), 32'd0);
        checkOutput("drop_frames", 32'(frame_count), 32'd1);
        checkOutput("drop_valid", 32'(rd_frame_valid), 32'd1);

        // rd_done arriving together with a publish lets the publish go ahead.
        doReset();
        sendFrame(1'b0, 16'h0100, 1'b0);
        sendFrame(1'b1, 16'h0200, 1'b1);
        checkOutput("pubdone_valid", 32'(rd_frame_valid), 32'd1);
        checkOutput("pubdone_rdbank", 32'(rd_bank), 32'd1);
        checkOutput("pubdone_frames", 32'(frame_count), 32'd2);
        checkOutput("pubdone_drops", 32'(drop_count), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("release_valid", 32'(rd_frame_valid), 32'd0);
        checkOutput("release_rdbank", 32'(rd_bank), 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("idle_done_valid", 32'(rd_frame_valid), 32'd0);

        // An early vsync aborts the frame; the pixel that arrives with it
        // restarts at index 0 of the same bank.
        doReset();
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            sendPixel(1'b0, 16'h0300 + 16'(k), {1'b0, 17'(k)});
        end
        sendPixel(1'b1, 16'h0400, {1'b0, 17'd0});
        checkOutput("short_count", 32'(short_count), 32'd1);
        for (int k = 1; k < FP; k++) begin
            sendPixel(1'b0, 16'h0400 + 16'(k), {1'b0, 17'(k)});
        end
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("short_frames", 32'(frame_count), 32'd1);
        checkOutput("short_rdbank", 32'(rd_bank), 32'd0);
        checkOutput("short_after", 32'(short_count), 32'd1);

        // Dropping enable mid-frame abandons the frame and stops writes.
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            sendPixel(1'b0, 16'h0500 + 16'(k), {1'b1, 17'(k)});
        end
        enable = 1'b0;
        applyStimulus(1'b0, 1'b1, 16'h0508, 1'b0);
        checkOutput("dis_wea", 32'(ram_wea), 32'd0);
        checkOutput("dis_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b1, 16'h0509, 1'b0);
        checkOutput("dis_wea2", 32'(ram_wea), 32'd0);
        checkOutput("dis_frames", 32'(frame_count), 32'd1);
        checkOutput("dis_drops", 32'(drop_count), 32'd0);
        checkOutput("dis_shorts", 32'(short_count), 32'd1);
        checkOutput("dis_valid", 32'(rd_frame_valid), 32'd1);
        checkOutput("dis_rdbank", 32'(rd_bank), 32'd0);
        enable = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
        sendPixel(1'b0, 16'h0600, {1'b1, 17'd0});
        sendPixel(1'b0, 16'h0601, {1'b1, 17'd1});

        // Reset in the middle of a capture cancels the pending write.
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 16'h0602, 1'b0);
        checkOutput("mid_rst_wea", 32'(ram_wea), 32'd0);
        checkOutput("mid_rst_addr", 32'(ram_addra), 32'd0);
        checkOutput("mid_rst_din", 32'(ram_dina), 32'd0);
        checkOutput("mid_rst_valid", 32'(rd_frame_valid), 32'd0);
        checkOutput("mid_rst_rdbank", 32'(rd_bank), 32'd1);
        checkOutput("mid_rst_frames", 32'(frame_count), 32'd0);
        checkOutput("mid_rst_shorts", 32'(short_count), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

        checkOutput("reader_bank_writes", 32'(badWrites), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_buffer_ctrl.md
Name: frame_buffer_ctrl

Overview:
- Double-buffered write-side controller for the camera frame-store RAM, which has a 16-bit write port and a 32-bit read port.
- Captures 16-bit camera pixels into one bank (RAM address MSB) and publishes each completed frame to the reader bank.
- Runs a handshake with the frame consumer (display/AHB reader) so that a bank being read is never overwritten.
- Sits between the camera pixel interface and the RAM write port.

Parameters:
- ADDR_WIDTH, 18: RAM address width; MSB selects the bank, the lower ADDR_WIDTH-1 bits give the pixel index.
- FRAME_PIXELS, 76800: pixels per frame (320x240). Must satisfy 1 <= FRAME_PIXELS <= 2**(ADDR_WIDTH-1).

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  synchronous reset, active-low.
- enable  in  1  capture enable.
- cam_vsync  in  1  frame sync; a rising edge marks frame start.
- cam_pix_valid  in  1  pixel strobe.
- cam_pix_data  in  16  RGB565 pixel.
- ram_wea  out  1  RAM write enable.
- ram_addra  out  ADDR_WIDTH  RAM write address.
- ram_dina  out  16  RAM write data.
- rd_frame_valid  out  1  a published frame is held for the reader.
- rd_bank  out  1  bank the reader must read.
- rd_done  in  1  one-cycle pulse: reader has finished and releases its bank.
- frame_count  out  16  frames published, wraps.
- drop_count  out  16  complete frames discarded because the reader held its bank, wraps.
- short_count  out  16  frames aborted by an early vsync, wraps.
- busy  out  1  high in CAPTURE.

Behaviour:
- Reset (rst_n=0 at a clk edge) values:
  - state=IDLE; wr_bank=0; rd_bank=1.
  - rd_frame_valid=0, ram_wea=0, ram_addra=0, ram_dina=0.
  - All counters=0; vsync_d=0; pix_idx=0.
- Vsync edge: vs_rise = cam_vsync & ~vsync_d, where vsync_d is a registered copy of cam_vsync.
- States:
  - IDLE: enable=1 -> WAIT_VS.
  - WAIT_VS:
    - On vs_rise -> CAPTURE with pix_idx=0.
    - Pixels arriving in WAIT_VS are ignored.
  - CAPTURE:
    - Each cam_pix_valid writes one pixel: next cycle ram_wea=1, ram_addra={wr_bank, pix_idx}, ram_dina=cam_pix_data. Write latency is exactly 1 cycle; otherwise ram_wea=0.
    - pix_idx increments per accepted pixel.
    - The pixel with pix_idx==FRAME_PIXELS-1 is written, then -> PUBLISH.
    - vs_rise before that point: frame aborted; short_count++; pix_idx=0; stay in CAPTURE, same bank.
    - If vs_rise and cam_pix_valid occur in the same cycle, that pixel is written at index 0 of the new frame.
  - PUBLISH (1 cycle, no writes, then -> WAIT_VS):
    - Evaluate the reader bank as free if rd_frame_valid=0 or rd_done=1 in this cycle.
    - Free: rd_bank<=wr_bank, wr_bank<=~wr_bank, rd_frame_valid<=1, frame_count++.
    - Not free: drop_count++, wr_bank unchanged, so the next frame overwrites the same bank.
- rd_done outside PUBLISH: rd_frame_valid<=0 next cycle; rd_bank holds its value. rd_done while rd_frame_valid=0 is ignored.
- Simultaneous rd_done and publish: publish wins; rd_frame_valid stays 1 and rd_bank takes the new bank.
- Invariant: when rd_frame_valid=1, no write address has MSB==rd_bank.
- enable=0 in any state:
  - Next cycle state=IDLE, ram_wea=0, pix_idx=0; the frame in progress is abandoned with no counter change.
  - rd_frame_valid, rd_bank and wr_bank are retained.
  - A write registered in the enable-drop cycle still completes.
- Reset mid-frame: returns to reset values at that edge; an in-flight write is cancelled (ram_wea=0).
- pix_idx width is ADDR_WIDTH-1 and never exceeds FRAME_PIXELS-1.

Test Plan:
- FRAME_PIXELS=16, enable=1, vsync pulse, 16 pixels 16'h0000..16'h000F -> writes to addresses 0..15, each 1 cycle after its strobe; then rd_frame_valid=1, rd_bank=0, wr_bank=1, frame_count=1.
- Reader never pulses rd_done; two more full frames -> both written at {1,idx}, drop_count=2, rd_bank stays 0, no write with MSB=0.
- rd_done in the same cycle as PUBLISH of frame 2 -> rd_frame_valid stays 1, rd_bank=1, frame_count=2, drop_count=0.
- vsync rise after 5 pixels, then 16 pixels -> short_count=1; the second run's first pixel lands at index 0 of the same bank; frame_count=1.
- enable dropped after pixel 7 -> IDLE next cycle, no further writes, counters unchanged; re-enable plus vsync -> capture restarts at index 0.
- rst_n=0 mid-capture with cam_pix_valid high -> ram_wea=0 on the following cycle, all outputs at reset values, rd_bank=1.
